// File: rtl/serial_to_parallel_lane_if.sv
// Serial lane bundle: bit stream into the deserializer, recovered bytes and lock status out.
interface serial_to_parallel_lane_if;
    logic       data_in;
    logic [7:0] data_stripe;
    logic       valid_stripe;
    logic       active;

    modport master (
        output data_in,
        input  data_stripe,
        input  valid_stripe,
        input  active
    );

    modport slave (
        input  data_in,
        output data_stripe,
        output valid_stripe,
        output active
    );
endinterface

// File: rtl/serial_to_parallel_lane.sv
// Per-lane deserializer: finds byte alignment with COM characters, then emits one byte per 8 bit times.
module serial_to_parallel_lane #(
    parameter logic [7:0]  COM      = 8'hBC,
    parameter int unsigned BC_COUNT = 4
) (
    input  logic                         clk_8f,
    input  logic                         reset,
    serial_to_parallel_lane_if.slave     lane
);

    typedef enum logic [1:0] {
        SEARCH,
        LOCKING,
        ACTIVE
    } state_e;

    localparam logic [3:0] BC_TARGET = 4'(BC_COUNT);

    state_e     state_q, state_d;
    // Only the seven most recent bits are stored; the eighth is data_in itself.
    logic [6:0] shift_q, shift_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [3:0] bc_cnt_q, bc_cnt_d;
    logic [7:0] data_stripe_q, data_stripe_d;
    logic       valid_stripe_q, valid_stripe_d;
    logic       active_q, active_d;

    logic [7:0] w;
    logic [3:0] bc_next;

    always_comb begin
        w              = {shift_q, lane.data_in};
        bc_next        = bc_cnt_q + 4'd1;
        shift_d        = w[6:0];
        bit_cnt_d      = bit_cnt_q + 3'd1;
        bc_cnt_d       = bc_cnt_q;
        state_d        = state_q;
        data_stripe_d  = data_stripe_q;
        valid_stripe_d = valid_stripe_q;
        active_d       = active_q;

        case (state_q)
            SEARCH: begin
                if (w == COM) begin
                    bit_cnt_d = '0;
                    bc_cnt_d  = 4'd1;
                    state_d   = LOCKING;
                end
            end
            LOCKING: begin
                if (bit_cnt_q == 3'd7) begin
                    if (w == COM) begin
                        bc_cnt_d = bc_next;
                        if (bc_next == BC_TARGET) begin
                            state_d  = ACTIVE;
                            active_d = 1'b1;
                        end
                    end else begin
                        bc_cnt_d = '0;
                        state_d  = SEARCH;
                    end
                end
            end
            ACTIVE: begin
                if (bit_cnt_q == 3'd7) begin
                    data_stripe_d  = w;
                    valid_stripe_d = (w != COM);
                end
            end
            default: state_d = SEARCH;
        endcase
    end

    always_ff @(posedge clk_8f or posedge reset) begin
        if (reset) begin
            state_q        <= SEARCH;
            shift_q        <= '0;
            bit_cnt_q      <= '0;
            bc_cnt_q       <= '0;
            data_stripe_q  <= '0;
            valid_stripe_q <= 1'b0;
            active_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            shift_q        <= shift_d;
            bit_cnt_q      <= bit_cnt_d;
            bc_cnt_q       <= bc_cnt_d;
            data_stripe_q  <= data_stripe_d;
            valid_stripe_q <= valid_stripe_d;
            active_q       <= active_d;
        end
    end

    assign lane.data_stripe  = data_stripe_q;
    assign lane.valid_stripe = valid_stripe_q;
    assign lane.active       = active_q;

endmodule

// File: tb/tb_serial_to_parallel_lane.sv
// Bench for serial_to_parallel_lane: stream-level reference model over the whole bit history.
module tb_serial_to_parallel_lane;

    localparam logic [7:0] COM = 8'hBC;

    logic clk_8f = 1'b0;
    logic reset  = 1'b1;

    serial_to_parallel_lane_if lane_a ();
    serial_to_parallel_lane_if lane_b ();

    serial_to_parallel_lane #(.COM(8'hBC), .BC_COUNT(4)) dut (
        .clk_8f (clk_8f),
        .reset  (reset),
        .lane   (lane_a)
    );

    serial_to_parallel_lane #(.COM(8'hBC), .BC_COUNT(2)) dut_bc2 (
        .clk_8f (clk_8f),
        .reset  (reset),
        .lane   (lane_b)
    );

    always #5 clk_8f = ~clk_8f;

    int checks   = 0;
    int failures = 0;

    bit         stim[$];
    bit         exp_act[$];
    bit         exp_val[$];
    logic [7:0] exp_dat[$];

    function automatic logic [7:0] win(input int e);
        logic [7:0] r;
        int idx;
        r = '0;
        for (int b = 0; b < 8; b++) begin
            idx = e - 7 + b;
            r = {r[6:0], (idx >= 0) ? stim[idx] : 1'b0};
        end
        return r;
    endfunction

    // Lock = first COM window, followed by bc-1 further COMs at 8-bit spacing;
    // a failed follow-up resumes the search one bit after the failing byte.
    function automatic void build_expect(input int bc);
        int n, i, j, k, lock, fail_at, e;
        bit done;
        logic [7:0] d;
        n = stim.size();
        lock = -1;
        i = 0;
        done = 1'b0;
        while (!done && i < n) begin
            if (win(i) == COM) begin
                fail_at = -1;
                k = 1;
                while (k < bc && fail_at < 0) begin
                    j = i + 8 * k;
                    if (j >= n) fail_at = n;
                    else if (win(j) != COM) fail_at = j;
                    k++;
                end
                if (fail_at < 0) begin
                    lock = i + 8 * (bc - 1);
                    done = 1'b1;
                end else begin
                    i = fail_at + 1;
                end
            end else begin
                i++;
            end
        end
        exp_act.delete();
        exp_val.delete();
        exp_dat.delete();
        for (int t = 0; t < n; t++) begin
            exp_act.push_back(lock >= 0 && t >= lock);
            if (lock >= 0 && t >= lock + 8) begin
                e = lock + 8 * ((t - lock) / 8);
                d = win(e);
                exp_dat.push_back(d);
                exp_val.push_back(d != COM);
            end else begin
                exp_dat.push_back(8'h00);
                exp_val.push_back(1'b0);
            end
        end
    endfunction

    task automatic push_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) stim.push_back(b[i]);
    endtask

    task automatic push_coms(input int n);
        for (int i = 0; i < n; i++) push_byte(COM);
    endtask

    task automatic push_random_bytes(input int n);
        for (int i = 0; i < n; i++)
            push_byte(($urandom_range(0, 3) == 0) ? COM : 8'($urandom));
    endtask

    task automatic drive(input int sel, input bit b);
        if (sel == 0) lane_a.data_in = b;
        else          lane_b.data_in = b;
        @(posedge clk_8f);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        lane_a.data_in = 1'b0;
        lane_b.data_in = 1'b0;
        repeat (2) @(posedge clk_8f);
        #1;
        reset = 1'b0;
        stim.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        lane_a.data_in = 1'($urandom);
        lane_b.data_in = 1'($urandom);
        repeat (3) @(posedge clk_8f);
        #1;
        checks++;
        if ({lane_a.active, lane_a.valid_stripe, lane_a.data_stripe} !== 10'h000) begin
            failures++;
            $display("FAIL reset_lane_a got act=%b val=%b data=%h exp 0/0/00",
                     lane_a.active, lane_a.valid_stripe, lane_a.data_stripe);
        end
        checks++;
        if ({lane_b.active, lane_b.valid_stripe, lane_b.data_stripe} !== 10'h000) begin
            failures++;
            $display("FAIL reset_lane_b got act=%b val=%b data=%h exp 0/0/00",
                     lane_b.active, lane_b.valid_stripe, lane_b.data_stripe);
        end
    endtask

    task automatic test_aligned_lock();
        do_reset();
        push_coms(4);
        push_byte(8'hA5);
        push_byte(8'h3C);
        push_random_bytes(2);
        build_expect(4);
        for (int t = 0; t < stim.size(); t++) begin
            drive(0, stim[t]);
            checks++;
            if ({lane_a.active, lane_a.valid_stripe, lane_a.data_stripe} !==
                {exp_act[t], exp_val[t], exp_dat[t]}) begin
                failures++;
                $display("FAIL aligned_lock t=%0d got act=%b val=%b data=%h exp act=%b val=%b data=%h",
                         t, lane_a.active, lane_a.valid_stripe, lane_a.data_stripe,
                         exp_act[t], exp_val[t], exp_dat[t]);
            end
        end
    endtask

    task automatic test_offset_lock();
        do_reset();
        stim.push_back(1'b1);
        stim.push_back(1'b0);
        stim.push_back(1'b1);
        push_coms(4);
        push_byte(8'h5A);
        push_random_bytes(2);
        build_expect(4);
        for (int t = 0; t < stim.size(); t++) begin
            drive(0, stim[t]);
            checks++;
            if ({lane_a.active, lane_a.valid_stripe, lane_a.data_stripe} !==
                {exp_act[t], exp_val[t], exp_dat[t]}) begin
                failures++;
                $display("FAIL offset_lock t=%0d got act=%b val=%b data=%h exp act=%b val=%b data=%h",
                         t, lane_a.active, lane_a.valid_stripe, lane_a.data_stripe,
                         exp_act[t], exp_val[t], exp_dat[t]);
            end
            checks++;
            if (lane_a.valid_stripe === 1'b1 && lane_a.active !== 1'b1) begin
                failures++;
                $display("FAIL valid_before_active t=%0d got act=%b exp 1", t, lane_a.active);
            end
        end
    endtask

    task automatic test_relock();
        do_reset();
        push_coms(3);
        push_byte(8'h00);
        push_coms(4);
        push_byte(8'h11);
        push_random_bytes(1);
        build_expect(4);
        for (int t = 0; t < stim.size(); t++) begin
            drive(0, stim[t]);
            checks++;
            if ({lane_a.active, lane_a.valid_stripe, lane_a.data_stripe} !==
                {exp_act[t], exp_val[t], exp_dat[t]}) begin
                failures++;
                $display("FAIL relock t=%0d got act=%b val=%b data=%h exp act=%b val=%b data=%h",
                         t, lane_a.active, lane_a.valid_stripe, lane_a.data_stripe,
                         exp_act[t], exp_val[t], exp_dat[t]);
            end
        end
    endtask

    task automatic test_idle_in_active();
        do_reset();
        push_coms(4);
        push_byte(8'h7E);
        push_byte(COM);
        push_byte(8'h81);
        push_random_bytes(3);
        build_expect(4);
        for (int t = 0; t < stim.size(); t++) begin
            drive(0, stim[t]);
            checks++;
            if ({lane_a.active, lane_a.valid_stripe, lane_a.data_stripe} !==
                {exp_act[t], exp_val[t], exp_dat[t]}) begin
                failures++;
                $display("FAIL idle_in_active t=%0d got act=%b val=%b data=%h exp act=%b val=%b data=%h",
                         t, lane_a.active, lane_a.valid_stripe, lane_a.data_stripe,
                         exp_act[t], exp_val[t], exp_dat[t]);
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        push_coms(4);
        push_byte(8'h66);
        stim.push_back(1'b1);
        stim.push_back(1'b0);
        stim.push_back(1'b0);
        build_expect(4);
        for (int t = 0; t < stim.size(); t++) begin
            drive(0, stim[t]);
            checks++;
            if ({lane_a.active, lane_a.valid_stripe, lane_a.data_stripe} !==
                {exp_act[t], exp_val[t], exp_dat[t]}) begin
                failures++;
                $display("FAIL pre_reset_stream t=%0d got act=%b val=%b data=%h exp act=%b val=%b data=%h",
                         t, lane_a.active, lane_a.valid_stripe, lane_a.data_stripe,
                         exp_act[t], exp_val[t], exp_dat[t]);
            end
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({lane_a.active, lane_a.valid_stripe, lane_a.data_stripe} !== 10'h000) begin
            failures++;
            $display("FAIL async_reset got act=%b val=%b data=%h exp 0/0/00",
                     lane_a.active, lane_a.valid_stripe, lane_a.data_stripe);
        end
        do_reset();
        push_coms(3);
        push_byte(8'h55);
        push_coms(4);
        push_byte(8'h42);
        push_random_bytes(2);
        build_expect(4);
        for (int t = 0; t < stim.size(); t++) begin
            drive(0, stim[t]);
            checks++;
            if ({lane_a.active, lane_a.valid_stripe, lane_a.data_stripe} !==
                {exp_act[t], exp_val[t], exp_dat[t]}) begin
                failures++;
                $display("FAIL post_reset_relock t=%0d got act=%b val=%b data=%h exp act=%b val=%b data=%h",
                         t, lane_a.active, lane_a.valid_stripe, lane_a.data_stripe,
                         exp_act[t], exp_val[t], exp_dat[t]);
            end
        end
    endtask

    task automatic test_bc_count_2();
        do_reset();
        push_coms(2);
        push_byte(8'hFF);
        push_random_bytes(3);
        build_expect(2);
        for (int t = 0; t < stim.size(); t++) begin
            drive(1, stim[t]);
            checks++;
            if ({lane_b.active, lane_b.valid_stripe, lane_b.data_stripe} !==
                {exp_act[t], exp_val[t], exp_dat[t]}) begin
                failures++;
                $display("FAIL bc_count_2 t=%0d got act=%b val=%b data=%h exp act=%b val=%b data=%h",
                         t, lane_b.active, lane_b.valid_stripe, lane_b.data_stripe,
                         exp_act[t], exp_val[t], exp_dat[t]);
            end
        end
    endtask

    task automatic test_random_streams();
        for (int it = 0; it < 6; it++) begin
            do_reset();
            for (int j = 0; j < int'($urandom_range(0, 15)); j++) stim.push_back(1'($urandom));
            push_coms(4);
            push_random_bytes(5);
            build_expect(4);
            for (int t = 0; t < stim.size(); t++) begin
                drive(0, stim[t]);
                checks++;
                if ({lane_a.active, lane_a.valid_stripe, lane_a.data_stripe} !==
                    {exp_act[t], exp_val[t], exp_dat[t]}) begin
                    failures++;
                    $display("FAIL random_stream it=%0d t=%0d got act=%b val=%b data=%h exp act=%b val=%b data=%h",
                             it, t, lane_a.active, lane_a.valid_stripe, lane_a.data_stripe,
                             exp_act[t], exp_val[t], exp_dat[t]);
                end
            end
        end
    endtask

    initial begin
        lane_a.data_in = 1'b0;
        lane_b.data_in = 1'b0;
        test_reset();
        test_aligned_lock();
        test_offset_lock();
        test_relock();
        test_idle_in_active();
        test_async_reset();
        test_bc_count_2();
        test_random_streams();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
